// File: rtl/sched_assign_pkg.sv
// sched_assign_pkg: shared width constants, slot record and helpers for the scheduled-assign register.
package sched_assign_pkg;

    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_WIDTH     = 3;
    localparam int DEF_CHANNELS  = 2;
    localparam int DEF_SLOTS     = 4;
    localparam int DEF_MAX_DELAY = 31;

    localparam int SLOT_CH_W   = clog2_min1(DEF_CHANNELS);
    localparam int SLOT_DATA_W = DEF_WIDTH;
    localparam int SLOT_CNT_W  = clog2_min1(DEF_MAX_DELAY + 1);

    typedef struct packed {
        logic                   valid;
        logic [SLOT_CH_W-1:0]   ch;
        logic [SLOT_DATA_W-1:0] data;
        logic [SLOT_CNT_W-1:0]  count;
    } slot_t;

endpackage

// File: rtl/sched_slot.sv
// sched_slot: one pending scheduled write; counts down and fires when its count reaches zero.
module sched_slot
    import sched_assign_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   load,
    input  slot_t                  load_rec,
    output logic                   busy,
    output logic                   fire,
    output logic [SLOT_CH_W-1:0]   ch,
    output logic [SLOT_DATA_W-1:0] data
);

    slot_t slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr)
            slot_d.valid = 1'b0;
        else if (load)
            slot_d = load_rec;
        else if (fire)
            slot_d.valid = 1'b0;
        else if (slot_q.valid)
            slot_d.count = slot_q.count - SLOT_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            slot_q <= '0;
        else
            slot_q <= slot_d;
    end

    assign busy = slot_q.valid;
    assign fire = slot_q.valid && (slot_q.count == '0);
    assign ch   = slot_q.ch;
    assign data = slot_q.data;

endmodule

// File: rtl/sched_assign_reg.sv
// sched_assign_reg: per-channel registers written by delayed scheduled writes held in a small slot pool.
module sched_assign_reg
    import sched_assign_pkg::*;
#(
    parameter int              WIDTH     = DEF_WIDTH,
    parameter int              CHANNELS  = DEF_CHANNELS,
    parameter int              SLOTS     = DEF_SLOTS,
    parameter int              MAX_DELAY = DEF_MAX_DELAY,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             CW        = clog2_min1(CHANNELS),
    localparam int             DW        = clog2_min1(MAX_DELAY + 1),
    localparam int             PW        = clog2_min1(SLOTS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [CW-1:0]             wr_ch,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [DW-1:0]             wr_delay,
    input  logic                      clr,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       upd,
    output logic [PW-1:0]             pending
);

    logic [SLOTS-1:0]             busy, fire, load, win, gone;
    logic [SLOT_CH_W-1:0]         ch_s [SLOTS];
    logic [SLOT_DATA_W-1:0]       data_s [SLOTS];
    logic [SLOTS-1:0][SLOTS-1:0]  age_q, age_d;
    logic [CHANNELS*WIDTH-1:0]    q_q, q_d;
    logic [CHANNELS-1:0]          upd_q, upd_d;
    logic [DW-1:0]                delay_c;
    logic                         accept;
    slot_t                        new_rec;

    assign wr_ready = ~&busy;
    assign accept   = wr_valid & wr_ready & ~clr;
    assign delay_c  = (32'(wr_delay) > 32'(MAX_DELAY)) ? DW'(MAX_DELAY) : wr_delay;
    assign new_rec  = '{valid: 1'b1, ch: SLOT_CH_W'(wr_ch), data: SLOT_DATA_W'(wr_data),
                        count: SLOT_CNT_W'(delay_c)};
    assign gone     = fire | {SLOTS{clr}};

    always_comb begin
        load = '0;
        for (int i = SLOTS - 1; i >= 0; i--)
            if (!busy[i]) load = SLOTS'(accept) << i;
    end

    // age_q[i][j] set means slot i was accepted before slot j
    always_comb begin
        win = fire & {SLOTS{~clr}};
        for (int i = 0; i < SLOTS; i++)
            for (int j = 0; j < SLOTS; j++)
                if (fire[j] && ch_s[j] == ch_s[i] && age_q[i][j]) win[i] = 1'b0;
    end

    always_comb begin
        age_d = '0;
        for (int i = 0; i < SLOTS; i++)
            for (int j = 0; j < SLOTS; j++)
                age_d[i][j] = load[i] ? 1'b0 :
                              load[j] ? (busy[i] & ~gone[i]) :
                                        (age_q[i][j] & ~gone[i] & ~gone[j]);
    end

    always_comb begin
        q_d   = q_q;
        upd_d = '0;
        for (int c = 0; c < CHANNELS; c++)
            for (int i = 0; i < SLOTS; i++)
                if (win[i] && ch_s[i] == SLOT_CH_W'(c)) begin
                    q_d[c*WIDTH +: WIDTH] = WIDTH'(data_s[i]);
                    upd_d[c]              = 1'b1;
                end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < SLOTS; i++)
            pending = pending + PW'(busy[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= {CHANNELS{RESET_VAL}};
            upd_q <= '0;
            age_q <= '0;
        end else begin
            q_q   <= q_d;
            upd_q <= upd_d;
            age_q <= age_d;
        end
    end

    assign q   = q_q;
    assign upd = upd_q;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        sched_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .load    (load[g]),
            .load_rec(new_rec),
            .busy    (busy[g]),
            .fire    (fire[g]),
            .ch      (ch_s[g]),
            .data    (data_s[g])
        );
    end

endmodule
